// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped peripheral window: register word
// indices, handshake state encoding and the hex-to-seven-segment glyph table.
package mmio_pkg;

    // Word index = byte offset / 4
    localparam int REG_LED      = 0;
    localparam int REG_SEG_DATA = 1;
    localparam int REG_SEG_CTRL = 2;
    localparam int REG_TIME_LO  = 3;
    localparam int REG_TIME_HI  = 4;
    localparam int REG_CMP_LO   = 5;
    localparam int REG_CMP_HI   = 6;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    // Active-high segment pattern {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/mmio_periph_seg7_scan.sv
// Multiplexed seven-segment scanner: steps through the digits, holding each
// for REFRESH_DIV clocks, and drives active-low anodes and segments.
module seg7_scan
    import mmio_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] data,
    input  logic [N_DIGITS-1:0]   en_mask,
    input  logic [N_DIGITS-1:0]   dp_mask,
    output logic [7:0]            sevenSeg,
    output logic [N_DIGITS-1:0]   sevenSegEn
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic [3:0]       nibble;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_q <= '0;
            idx_q <= (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Outputs are combinational from the registers so a data write shows next cycle
    always_comb begin
        nibble     = data[4*idx_q +: 4];
        sevenSeg   = 8'hFF;
        sevenSegEn = '1;
        if (en_mask[idx_q]) begin
            sevenSegEn[idx_q] = 1'b0;
            sevenSeg          = {~dp_mask[idx_q], ~hex_to_seg(nibble)};
        end
    end

endmodule

// File: rtl/mmio_periph.sv
// Memory-mapped peripheral: LEDs, multiplexed hex display and a 64-bit cycle timer
// behind the execute/ready/dataReady handshake. Define MMIO_TIMER_CMP_EN for the timer compare IRQ.
module mmio_periph
    import mmio_pkg::*;
#(
    parameter int LED_W       = 8,
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int ADDR_W      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sel,
    input  logic                memExecute,
    input  logic                memWrite,
    input  logic [1:0]          memSize,
    input  logic [ADDR_W-1:0]   memAddress,
    input  logic [31:0]         inputData,
    output logic                memReady,
    output logic                dataReady,
    output logic [31:0]         outputData,
    output logic [LED_W-1:0]    ledState,
    output logic [7:0]          sevenSeg,
    output logic [N_DIGITS-1:0] sevenSegEn
`ifdef MMIO_TIMER_CMP_EN
    ,
    output logic                timerIrq
`endif
);
    localparam int WI_W = ADDR_W - 2;

    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wdata,
                                               input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~m) | (wdata & m);
    endfunction

    logic [0:0]            state_q;
    logic [LED_W-1:0]      led_q;
    logic [4*N_DIGITS-1:0] seg_data_q;
    logic [N_DIGITS-1:0]   en_q;
    logic [N_DIGITS-1:0]   dp_q;
    logic [63:0]           timer_q;
    logic [31:0]           snap_q;
    logic [31:0]           rdata_q;
`ifdef MMIO_TIMER_CMP_EN
    logic [63:0]           cmp_q;
    logic                  irq_q;
`endif

    logic            accept;
    logic [WI_W-1:0] widx;
    logic [1:0]      off;
    logic [3:0]      be;
    logic [31:0]     wdata;
    logic [31:0]     ctrl_rd;
    logic [31:0]     rdata;
    logic [63:0]     timer_nxt;

    assign accept    = (state_q == ST_IDLE) && sel && memExecute;
    assign widx      = memAddress[ADDR_W-1:2];
    assign off       = memAddress[1:0];
    assign timer_nxt = timer_q + 64'd1;
    assign ctrl_rd   = (32'(dp_q) << 8) | 32'(en_q);

    // Misaligned halves/words get no byte enables, so the store is dropped but acked
    always_comb begin
        case (memSize)
            2'd0:    be = 4'b0001 << off;
            2'd1:    be = off[0] ? 4'b0000 : (4'b0011 << off);
            default: be = (off == 2'b00) ? 4'b1111 : 4'b0000;
        endcase
        wdata = inputData << {off, 3'b000};
    end

    // TIME_LO returns the count visible during the ACK cycle, coherent with the HI snapshot
    always_comb begin
        rdata = '0;
        if (widx == WI_W'(REG_LED))      rdata = 32'(led_q);
        if (widx == WI_W'(REG_SEG_DATA)) rdata = 32'(seg_data_q);
        if (widx == WI_W'(REG_SEG_CTRL)) rdata = ctrl_rd;
        if (widx == WI_W'(REG_TIME_LO))  rdata = timer_nxt[31:0];
        if (widx == WI_W'(REG_TIME_HI))  rdata = snap_q;
`ifdef MMIO_TIMER_CMP_EN
        if (widx == WI_W'(REG_CMP_LO))   rdata = cmp_q[31:0];
        if (widx == WI_W'(REG_CMP_HI))   rdata = cmp_q[63:32];
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            led_q      <= '0;
            seg_data_q <= '0;
            en_q       <= '0;
            dp_q       <= '0;
            timer_q    <= '0;
            snap_q     <= '0;
`ifdef MMIO_TIMER_CMP_EN
            cmp_q      <= '1;
`endif
        end else begin
            timer_q <= timer_nxt;
            state_q <= accept ? ST_ACK : ST_IDLE;
            if (accept && memWrite) begin
                if (widx == WI_W'(REG_LED))
                    led_q <= LED_W'(lane_merge(32'(led_q), wdata, be));
                if (widx == WI_W'(REG_SEG_DATA))
                    seg_data_q <= (4*N_DIGITS)'(lane_merge(32'(seg_data_q), wdata, be));
                if (widx == WI_W'(REG_SEG_CTRL)) begin
                    en_q <= N_DIGITS'(lane_merge(ctrl_rd, wdata, be));
                    dp_q <= N_DIGITS'(lane_merge(ctrl_rd, wdata, be) >> 8);
                end
`ifdef MMIO_TIMER_CMP_EN
                if (widx == WI_W'(REG_CMP_LO))
                    cmp_q[31:0] <= lane_merge(cmp_q[31:0], wdata, be);
                if (widx == WI_W'(REG_CMP_HI))
                    cmp_q[63:32] <= lane_merge(cmp_q[63:32], wdata, be);
`endif
            end
            if (accept && !memWrite && widx == WI_W'(REG_TIME_LO))
                snap_q <= timer_nxt[63:32];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) rdata_q <= memWrite ? 32'd0 : rdata;
    end

    assign memReady   = (state_q == ST_IDLE);
    assign dataReady  = (state_q == ST_ACK);
    assign outputData = dataReady ? rdata_q : 32'd0;
    assign ledState   = led_q;

`ifdef MMIO_TIMER_CMP_EN
    always_ff @(posedge clk) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= (timer_q >= cmp_q);
    end
    assign timerIrq = irq_q;
`endif

    seg7_scan #(
        .N_DIGITS    (N_DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_scan (
        .clk        (clk),
        .reset      (reset),
        .data       (seg_data_q),
        .en_mask    (en_q),
        .dp_mask    (dp_q),
        .sevenSeg   (sevenSeg),
        .sevenSegEn (sevenSegEn)
    );

endmodule

// File: tb/tb_mmio_periph.sv
// Scoreboard bench for mmio_periph: randomized loads/stores against a register-level
// reference model, plus display scan, timer wrap and reset checks.
module tb_mmio_periph;
    localparam int LED_W = 8, N_DIGITS = 4, REFRESH_DIV = 4, ADDR_W = 8;
    localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic clk = 1'b0, reset = 1'b1, sel = 1'b0, memExecute = 1'b0, memWrite = 1'b0;
    logic [1:0] memSize = 2'd0;
    logic [ADDR_W-1:0] memAddress = '0;
    logic [31:0] inputData = '0;
    logic memReady, dataReady;
    logic [31:0] outputData;
    logic [LED_W-1:0] ledState;
    logic [7:0] sevenSeg;
    logic [N_DIGITS-1:0] sevenSegEn;
`ifdef MMIO_TIMER_CMP_EN
    logic timerIrq;
`endif

    mmio_periph #(.LED_W(LED_W), .N_DIGITS(N_DIGITS), .REFRESH_DIV(REFRESH_DIV), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .sel(sel), .memExecute(memExecute), .memWrite(memWrite),
        .memSize(memSize), .memAddress(memAddress), .inputData(inputData),
        .memReady(memReady), .dataReady(dataReady), .outputData(outputData),
        .ledState(ledState), .sevenSeg(sevenSeg), .sevenSegEn(sevenSegEn)
`ifdef MMIO_TIMER_CMP_EN
        , .timerIrq(timerIrq)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit mon_on = 1'b0;
    int unsigned tick = 0;
    longint unsigned cyc = 0;
    logic [63:0] offset = '0;

    always @(posedge clk) tick <= tick + 1;
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        logic [31:0] data;
        logic [7:0]  led;
        int unsigned tick;
    } exp_t;
    exp_t sb[$];

    logic [31:0] m_led = '0, m_seg = '0, m_ctrl = '0, m_snap = '0;
    logic [63:0] m_cmp = '1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_time();
        return cyc + offset;
    endfunction

    function automatic int anode_idx(input logic [3:0] en);
        case (en)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_store(input logic [1:0] size, input logic [7:0] addr, input logic [31:0] d);
        int nb, o;
        logic [31:0] old, nw;
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        o  = int'(addr[1:0]);
        if (o % nb != 0) return;
        case (addr & 8'hFC)
            8'h00: old = m_led;
            8'h04: old = m_seg;
            8'h08: old = m_ctrl;
`ifdef MMIO_TIMER_CMP_EN
            8'h14: old = m_cmp[31:0];
            8'h18: old = m_cmp[63:32];
`endif
            default: return;
        endcase
        nw = old;
        for (int i = 0; i < nb; i++) nw[8*(o+i) +: 8] = d[8*i +: 8];
        case (addr & 8'hFC)
            8'h00: m_led  = nw & 32'h0000_00FF;
            8'h04: m_seg  = nw & 32'h0000_FFFF;
            8'h08: m_ctrl = nw & 32'h0000_0F0F;
`ifdef MMIO_TIMER_CMP_EN
            8'h14: m_cmp[31:0]  = nw;
            8'h18: m_cmp[63:32] = nw;
`endif
            default: ;
        endcase
    endtask

    task automatic model_load(input logic [7:0] addr, output logic [31:0] r);
        logic [63:0] t;
        r = '0;
        case (addr & 8'hFC)
            8'h00: r = m_led;
            8'h04: r = m_seg;
            8'h08: r = m_ctrl;
            8'h0C: begin
                t = ref_time() + 64'd1;
                m_snap = t[63:32];
                r = t[31:0];
            end
            8'h10: r = m_snap;
`ifdef MMIO_TIMER_CMP_EN
            8'h14: r = m_cmp[31:0];
            8'h18: r = m_cmp[63:32];
`endif
            default: r = '0;
        endcase
    endtask

    // Called at a falling edge; returns at the falling edge after the ack cycle
    task automatic req(input bit w, input logic [1:0] size, input logic [7:0] addr, input logic [31:0] data);
        exp_t e;
        int n;
        n = 0;
        while (memReady !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (memReady !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=%b required=1", memReady);
        end
        e.tick = tick;
        if (w) begin
            model_store(size, addr, data);
            e.data = '0;
        end else begin
            model_load(addr, e.data);
        end
        e.led = m_led[7:0];
        sb.push_back(e);
        sel = 1'b1; memExecute = 1'b1; memWrite = w;
        memSize = size; memAddress = addr; inputData = data;
        @(negedge clk);
        memExecute = 1'($urandom_range(0, 1));
        memWrite   = 1'($urandom_range(0, 1));
        @(negedge clk);
        sel = 1'b0; memExecute = 1'b0;
    endtask

    task automatic noise();
        int k;
        k = $urandom_range(0, 2);
        sel        = (k == 1);
        memExecute = (k == 2);
        memWrite   = 1'($urandom_range(0, 1));
        @(negedge clk);
        sel = 1'b0; memExecute = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            bit exp_ack;
            while (sb.size() > 0 && sb[0].tick + 1 < tick) begin
                checks++;
                errors++;
                $display("FAIL missing_ack issued_tick=%0d now=%0d", sb[0].tick, tick);
                sb.delete(0);
            end
            exp_ack = (sb.size() > 0) && (sb[0].tick + 1 == tick);
            check("dataReady", dataReady, exp_ack);
            check("memReady", memReady, !exp_ack);
            if (exp_ack) begin
                check("outputData", outputData, sb[0].data);
                check("ledState", ledState, sb[0].led);
                sb.delete(0);
            end else begin
                check("idle_outputData", outputData, 32'd0);
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog_timeout tick=%0d", tick);
        $fatal(1, "watchdog");
    end

    initial begin
        int d, prev, run, seen0, seen2;
        bit changed, ok_en;
        logic [7:0] exp_seg;
        logic [63:0] fv;
        logic [63:0] wraps [2];
        logic [7:0] a;
        wraps[0] = 64'hFFFF_FFFF_FFFF_FFFE;
        wraps[1] = 64'hFFFF_FFFF_FFFF_FFFF;

        // Reset with a store request pending: must be ignored
        reset = 1'b1; sel = 1'b1; memExecute = 1'b1; memWrite = 1'b1;
        memSize = 2'd2; memAddress = '0; inputData = 32'hFF;
        repeat (3) @(negedge clk);
        check("rst_memReady", memReady, 1);
        check("rst_dataReady", dataReady, 0);
        check("rst_outputData", outputData, 0);
        check("rst_ledState", ledState, 0);
        check("rst_sevenSegEn", sevenSegEn, 4'hF);
        check("rst_sevenSeg", sevenSeg, 8'hFF);
`ifdef MMIO_TIMER_CMP_EN
        check("rst_timerIrq", timerIrq, 0);
`endif
        reset = 1'b0; sel = 1'b0; memExecute = 1'b0;
        mon_on = 1'b1;
        repeat (2) @(negedge clk);

        // Directed: LED word store/load, byte lane and misaligned half
        req(1, 2'd2, 8'h00, 32'h0000_00A5);
        check("led_a5", ledState, 8'hA5);
        req(0, 2'd2, 8'h00, 32'h0);
        req(1, 2'd2, 8'h04, 32'h0000_1234);
        req(1, 2'd0, 8'h05, 32'h0000_003C);
        req(0, 2'd2, 8'h04, 32'h0);
        req(1, 2'd1, 8'h01, 32'h0000_FFFF);
        req(0, 2'd0, 8'h00, 32'h0);
        req(0, 2'd2, 8'h10, 32'h0);

`ifdef MMIO_TIMER_CMP_EN
        begin
            logic [63:0] cmpv;
            int n;
            cmpv = ref_time() + 64'd40;
            req(1, 2'd2, 8'h18, cmpv[63:32]);
            req(1, 2'd2, 8'h14, cmpv[31:0]);
            n = 0;
            while (timerIrq !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("irq_rise_time", ref_time() - 64'd1, cmpv);
            req(1, 2'd2, 8'h14, 32'hFFFF_FFFF);
            req(1, 2'd2, 8'h18, 32'hFFFF_FFFF);
            check("irq_clear", timerIrq, 0);
        end
`endif

        // Display scan: all digits enabled, no decimal points
        req(1, 2'd2, 8'h04, 32'h0000_1234);
        req(1, 2'd2, 8'h08, 32'h0000_000F);
        prev = -1; run = 0; changed = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            d = anode_idx(sevenSegEn);
            check("scan_onehot", (d >= 0), 1);
            if (d >= 0) begin
                check("scan_seg", sevenSeg, {1'b1, ~GLYPH[m_seg[4*d +: 4]]});
                if (d != prev) begin
                    if (prev >= 0) begin
                        check("scan_order", d, (prev + 1) % N_DIGITS);
                        if (changed) check("scan_len", run, REFRESH_DIV);
                        changed = 1'b1;
                    end
                    prev = d;
                    run = 1;
                end else begin
                    run++;
                end
            end
        end

        // Digits 0 and 2 enabled, decimal point on digit 0
        req(1, 2'd2, 8'h08, 32'h0000_0105);
        seen0 = 0; seen2 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ok_en = 1'b1;
            case (sevenSegEn)
                4'b1111: exp_seg = 8'hFF;
                4'b1110: begin exp_seg = {1'b0, ~GLYPH[m_seg[3:0]]};  seen0++; end
                4'b1011: begin exp_seg = {1'b1, ~GLYPH[m_seg[11:8]]}; seen2++; end
                default: begin exp_seg = 8'hFF; ok_en = 1'b0; end
            endcase
            check("mask_anode", ok_en, 1);
            check("mask_seg", sevenSeg, exp_seg);
        end
        check("mask_digit0_seen", (seen0 > 0), 1);
        check("mask_digit2_seen", (seen2 > 0), 1);

        // Timer wrap coherence
        for (int k = 0; k < 2; k++) begin
            fv = wraps[k];
            force dut.timer_q = fv;
            offset = fv - cyc;
            #1;
            release dut.timer_q;
            req(0, 2'd2, 8'h0C, 32'h0);
            req(0, 2'd2, 8'h10, 32'h0);
            req(0, 2'd2, 8'h0C, 32'h0);
            req(0, 2'd2, 8'h10, 32'h0);
        end

        // Randomized traffic
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 4) == 0) noise();
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
            req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
